reset_sequencer: RTL

- Generates the reset outputs for NUM_STAGES downstream reset domains; the synchronizers consume these outputs.
- Holds all stage resets asserted for a minimum time, then releases them one at a time in index order.
- Each release waits for that stage's ready acknowledge, or for a timeout, before the next stage is released.
- A software/watchdog request (i_req) re-asserts every stage and restarts the sequence.

---
 rtl/reset_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all downstream reset domains asserted for a minimum
// time, then releases them one by one, each gated by its ack or a timeout.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int MIN_ASSERT  = 16,
  parameter int STAGE_GAP   = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                              clk,
  input  logic                              i_rst,
  input  logic                              i_req,
  input  logic [NUM_STAGES-1:0]             i_ack,
  output logic [NUM_STAGES-1:0]             o_rst,
  output logic                              o_busy,
  output logic [$clog2(NUM_STAGES+1)-1:0]   o_stage,
  output logic                              o_timeout
);

  localparam int SW      = $clog2(NUM_STAGES + 1);
  localparam int MAX_AB  = (MIN_ASSERT > STAGE_GAP) ? MIN_ASSERT : STAGE_GAP;
  localparam int MAX_CNT = (MAX_AB > ACK_TIMEOUT) ? MAX_AB : ACK_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_ASSERT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [SW-1:0] DONE_STAGE = SW'(NUM_STAGES);

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT_ACK,
    S_GAP,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           k_q, k_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    busy_q, busy_d;
  logic                    timeout_q, timeout_d;
  logic                    ack_sel;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    rst_d     = rst_q;
    busy_d    = busy_q;
    timeout_d = timeout_q;
    ack_sel   = 1'b0;

    // Only the ack of the stage currently being waited on matters.
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (k_q == SW'(i)) ack_sel = i_ack[i];
    end

    if (i_req) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      k_d     = '0;
      rst_d   = '1;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d  = S_WAIT_ACK;
            cnt_d    = '0;
            k_d      = '0;
            rst_d[0] = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_WAIT_ACK: begin
          if (ack_sel || (cnt_q == ACK_LAST)) begin
            if (!ack_sel) timeout_d = 1'b1;
            cnt_d = '0;
            if (k_q == LAST_STAGE) begin
              state_d = S_DONE;
              k_d     = DONE_STAGE;
              busy_d  = 1'b0;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_WAIT_ACK;
            cnt_d   = '0;
            k_d     = k_q + SW'(1);
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (k_q + SW'(1) == SW'(i)) rst_d[i] = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_DONE: ;

        default: state_d = S_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      k_q       <= '0;
      rst_q     <= '1;
      busy_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments only.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      rst_q     <= rst_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_rst     = rst_q;
  assign o_busy    = busy_q;
  assign o_stage   = k_q;
  assign o_timeout = timeout_q;

endmodule
